// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared register map constants for the uart receive buffer
package uart_pkg;

    // Register window addresses
    localparam logic UART_RXF_DATA = 1'b0;
    localparam logic UART_RXF_STAT = 1'b1;

    // Status/control register bit positions
    localparam int NOT_EMPTY = 0;
    localparam int FULL      = 1;
    localparam int FRAME_ERR = 2;
    localparam int OVERRUN   = 3;
    localparam int IRQ_EN    = 4;
    localparam int FLUSH     = 31;
    localparam int LEVEL_LSB = 8;

endpackage

// File: rtl/uart_rx_fifo_core.sv
// rtl/uart_rx_fifo_core.sv - synchronous fifo with separate level counter and flush
module sync_fifo_core #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic                  pop,
    input  logic                  flush,
    input  logic [7:0]            wdata,
    output logic [7:0]            rdata,
    output logic [DEPTH_LOG2:0]   level,
    output logic [DEPTH_LOG2:0]   level_next,
    output logic                  full,
    output logic                  empty
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   DEPTH_CNT = DEPTH[DEPTH_LOG2:0];
    localparam logic [DEPTH_LOG2:0]   LVL_ONE   = 1;
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = 1;

    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic                  push_ok;
    logic                  pop_ok;

    assign full    = (level == DEPTH_CNT);
    assign empty   = (level == '0);
    // A full fifo still accepts a byte when a pop frees a slot in the same cycle
    assign push_ok = push & (~full | pop);
    assign pop_ok  = pop & ~empty;
    assign rdata   = mem[rd_ptr];

    // Next fill count; flush overrides any push/pop in the same cycle
    always_comb begin
        level_next = level;
        if (flush) begin
            level_next = '0;
        end else if (push_ok && !pop_ok) begin
            level_next = level + LVL_ONE;
        end else if (pop_ok && !push_ok) begin
            level_next = level - LVL_ONE;
        end
    end

    // Pointer and level registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            level <= level_next;
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
                if (pop_ok)  rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

    // Storage write; array contents are deliberately not reset
    always_ff @(posedge clk) begin
        if (push_ok && !flush) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - uart receive buffer with sticky flags, register window and irq
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH_LOG2 = 4,
    parameter int IRQ_LEVEL  = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                rx_valid,
    input  logic                rx_err,
    input  logic [7:0]          rx_byte,
    input  logic                read_en,
    input  logic                write_en,
    input  logic                addr,
    input  logic [31:0]         write_val,
    output logic [31:0]         read_val,
    output logic [DEPTH_LOG2:0] level,
    output logic                irq
);

    localparam logic [DEPTH_LOG2:0] IRQ_LVL = IRQ_LEVEL[DEPTH_LOG2:0];

    logic [7:0]            rdata;
    logic [DEPTH_LOG2:0]   level_next;
    logic                  full;
    logic                  empty;
    logic                  pop_req;
    logic                  stat_wr;
    logic                  flush;
    logic                  overrun;
    logic                  frame_err;
    logic                  irq_en;
    logic                  overrun_next;
    logic                  frame_err_next;
    logic                  irq_en_next;
    logic [31:0]           status;
    logic                  unused_write_bits;

    assign pop_req = read_en & (addr == UART_RXF_DATA);
    assign stat_wr = write_en & (addr == UART_RXF_STAT);
    assign flush   = stat_wr & write_val[FLUSH];
    assign unused_write_bits = ^{write_val[30:5], write_val[1:0]};

    sync_fifo_core #(
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_core (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (rx_valid),
        .pop       (pop_req),
        .flush     (flush),
        .wdata     (rx_byte),
        .rdata     (rdata),
        .level     (level),
        .level_next(level_next),
        .full      (full),
        .empty     (empty)
    );

    // Sticky flag and enable updates; a clear write beats a same-cycle set
    always_comb begin
        overrun_next   = overrun;
        frame_err_next = frame_err;
        irq_en_next    = irq_en;
        if (rx_valid && full && !pop_req && !flush) overrun_next = 1'b1;
        if (rx_err) frame_err_next = 1'b1;
        if (stat_wr) begin
            if (write_val[OVERRUN])   overrun_next   = 1'b0;
            if (write_val[FRAME_ERR]) frame_err_next = 1'b0;
            irq_en_next = write_val[IRQ_EN];
        end
    end

    // Status word assembled from the state before this cycle's update
    always_comb begin
        status            = 32'(level) << LEVEL_LSB;
        status[NOT_EMPTY] = ~empty;
        status[FULL]      = full;
        status[FRAME_ERR] = frame_err;
        status[OVERRUN]   = overrun;
        status[IRQ_EN]    = irq_en;
    end

    // Flag, read data and interrupt registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun   <= 1'b0;
            frame_err <= 1'b0;
            irq_en    <= 1'b0;
            read_val  <= '0;
            irq       <= 1'b0;
        end else begin
            overrun   <= overrun_next;
            frame_err <= frame_err_next;
            irq_en    <= irq_en_next;
            irq       <= irq_en & ((level_next >= IRQ_LVL) | overrun_next | frame_err_next);
            if (read_en) begin
                if (addr == UART_RXF_STAT) begin
                    read_val <= status;
                end else if (empty) begin
                    read_val <= '0;
                end else begin
                    read_val <= {23'b0, 1'b1, rdata};
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - directed self-checking bench for uart_rx_fifo
module tb_uart_rx_fifo;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx_valid = 1'b0;
    logic        rx_err = 1'b0;
    logic [7:0]  rx_byte = '0;
    logic        read_en = 1'b0;
    logic        write_en = 1'b0;
    logic        addr = 1'b0;
    logic [31:0] write_val = '0;
    logic [31:0] read_val;
    logic [4:0]  level;
    logic        irq;

    int errors = 0;
    int checks = 0;
    logic [31:0] v;

    uart_rx_fifo #(.DEPTH_LOG2(4), .IRQ_LEVEL(1)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx_valid (rx_valid),
        .rx_err   (rx_err),
        .rx_byte  (rx_byte),
        .read_en  (read_en),
        .write_en (write_en),
        .addr     (addr),
        .write_val(write_val),
        .read_val (read_val),
        .level    (level),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_byte  = b;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic do_read(input logic a, output logic [31:0] r);
        read_en = 1'b1;
        addr    = a;
        tick();
        read_en = 1'b0;
        r       = read_val;
    endtask

    task automatic write_stat(input logic [31:0] w);
        write_en  = 1'b1;
        addr      = 1'b1;
        write_val = w;
        tick();
        write_en  = 1'b0;
    endtask

    initial begin
        // Reset and idle status
        #1;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check("reset_irq", 32'(irq), 32'h0);
        check("reset_level", 32'(level), 32'h0);
        do_read(1'b1, v);
        check("reset_status", v, 32'h0);

        // Three spaced pushes then reads, then read on empty
        push_byte(8'h41); tick();
        push_byte(8'h42); tick();
        push_byte(8'h43); tick();
        check("level3", 32'(level), 32'd3);
        do_read(1'b0, v); check("rd_41", v, 32'h141);
        do_read(1'b0, v); check("rd_42", v, 32'h142);
        do_read(1'b0, v); check("rd_43", v, 32'h143);
        check("level_before_empty_rd", 32'(level), 32'd0);
        do_read(1'b0, v); check("rd_empty", v, 32'h0);
        check("level_after_empty_rd", 32'(level), 32'd0);

        // Overfill by one: last byte dropped, overrun sticky
        for (int i = 0; i < 17; i++) push_byte(8'(i));
        check("level_full", 32'(level), 32'd16);
        do_read(1'b1, v); check("status_full_ovr", v, 32'h0000100B);
        for (int i = 0; i < 16; i++) begin
            do_read(1'b0, v);
            check($sformatf("drain_%0d", i), v, 32'h100 | 32'(i));
        end
        write_stat(32'h8);
        do_read(1'b1, v); check("status_ovr_cleared", v, 32'h0);

        // Push and pop together while full
        for (int i = 0; i < 16; i++) push_byte(8'h20 + 8'(i));
        rx_valid = 1'b1; rx_byte = 8'h55;
        do_read(1'b0, v);
        rx_valid = 1'b0;
        check("full_pushpop_rd", v, 32'h120);
        check("full_pushpop_level", 32'(level), 32'd16);
        do_read(1'b1, v); check("full_pushpop_status", v, 32'h00001003);
        for (int i = 1; i < 16; i++) begin
            do_read(1'b0, v);
            check($sformatf("wrap_%0d", i), v, 32'h100 | (32'h20 + 32'(i)));
        end
        do_read(1'b0, v); check("wrap_55", v, 32'h155);

        // Interrupt on level and on framing error
        write_stat(32'h10);
        check("irq_idle", 32'(irq), 32'h0);
        push_byte(8'h7E);
        check("irq_level", 32'(irq), 32'h1);
        do_read(1'b0, v); check("rd_7e", v, 32'h17E);
        check("irq_after_rd", 32'(irq), 32'h0);
        rx_err = 1'b1; tick(); rx_err = 1'b0;
        check("irq_ferr", 32'(irq), 32'h1);
        do_read(1'b1, v); check("status_ferr", v, 32'h14);
        rx_err = 1'b1;
        write_stat(32'h14);
        rx_err = 1'b0;
        check("irq_ferr_clear", 32'(irq), 32'h0);
        do_read(1'b1, v); check("status_ferr_clear_wins", v, 32'h10);

        // Flush beats a same-cycle push
        for (int i = 0; i < 5; i++) push_byte(8'h60 + 8'(i));
        check("level5", 32'(level), 32'd5);
        rx_valid = 1'b1; rx_byte = 8'h99;
        write_stat(32'h80000010);
        rx_valid = 1'b0;
        check("flush_level", 32'(level), 32'd0);
        check("flush_irq", 32'(irq), 32'h0);
        do_read(1'b1, v); check("flush_status", v, 32'h10);
        do_read(1'b0, v); check("flush_rd_empty", v, 32'h0);

        // Asynchronous reset mid-fill
        for (int i = 0; i < 3; i++) push_byte(8'hA0 + 8'(i));
        do_read(1'b1, v); check("prereset_status", v, 32'h311);
        check("prereset_irq", 32'(irq), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_read_val", read_val, 32'h0);
        check("async_rst_level", 32'(level), 32'h0);
        check("async_rst_irq", 32'(irq), 32'h0);
        tick();
        rst_n = 1'b1;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
